// File: rtl/primitives.sv
// Parameterized counter and register primitives plus a wrapper top
// instantiating the widths the USB protocol FSMs use.

module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr_cnt,
  input  logic             inc_cnt,
  input  logic             up,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (inc_cnt) begin
      if (up) cnt <= cnt + WIDTH'(1);
      else    cnt <= cnt - WIDTH'(1);
    end
  end

endmodule

module register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr_reg,
  input  logic             ld_reg,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      Q <= '0;
    end else if (clr_reg) begin
      Q <= '0;
    end else if (ld_reg) begin
      Q <= D;
    end
  end

endmodule

module primitives (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        clr_cnt4,
  input  logic        inc_cnt4,
  input  logic        up4,
  output logic [3:0]  cnt4,
  input  logic        clr_cnt20,
  input  logic        inc_cnt20,
  input  logic        up20,
  output logic [19:0] cnt20,
  input  logic        clr_reg,
  input  logic        ld_reg,
  input  logic [63:0] d,
  output logic [63:0] q
);

  // Retry counter, cycle timer and payload register
  counter #(.WIDTH(4)) u_cnt4 (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr_cnt (clr_cnt4),
    .inc_cnt (inc_cnt4),
    .up      (up4),
    .cnt     (cnt4)
  );

  counter #(.WIDTH(20)) u_cnt20 (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr_cnt (clr_cnt20),
    .inc_cnt (inc_cnt20),
    .up      (up20),
    .cnt     (cnt20)
  );

  register #(.WIDTH(64)) u_reg (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr_reg (clr_reg),
    .ld_reg  (ld_reg),
    .D       (d),
    .Q       (q)
  );

endmodule

// File: tb/tb_primitives.sv
// Bench for the counter/register primitives: model values are pushed
// to scoreboard queues as stimulus is driven and popped after the edge.

module tb_primitives;

  logic        clk = 0;
  logic        rst_b = 0;
  logic        clr_cnt4 = 0, inc_cnt4 = 0, up4 = 0;
  logic        clr_cnt20 = 0, inc_cnt20 = 0, up20 = 0;
  logic        clr_reg = 0, ld_reg = 0;
  logic [63:0] d = '0;
  logic [3:0]  cnt4;
  logic [19:0] cnt20;
  logic [63:0] q;

  int n_checks = 0;
  int n_fail = 0;

  logic [3:0]  m4;
  logic [19:0] m20;
  logic [63:0] mq;

  logic [3:0]  sb4[$];
  logic [19:0] sb20[$];
  logic [63:0] sbq[$];

  primitives dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .clr_cnt4  (clr_cnt4),
    .inc_cnt4  (inc_cnt4),
    .up4       (up4),
    .cnt4      (cnt4),
    .clr_cnt20 (clr_cnt20),
    .inc_cnt20 (inc_cnt20),
    .up20      (up20),
    .cnt20     (cnt20),
    .clr_reg   (clr_reg),
    .ld_reg    (ld_reg),
    .d         (d),
    .q         (q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr_cnt4 = 0; inc_cnt4 = 0; up4 = 0;
    clr_cnt20 = 0; inc_cnt20 = 0; up20 = 0;
    clr_reg = 0; ld_reg = 0;
  endtask

  task automatic test_reset();
    logic [3:0]  e4;
    logic [19:0] e20;
    logic [63:0] eq;
    #2;
    sb4.push_back(4'd0); sb20.push_back(20'd0); sbq.push_back(64'd0);
    e4 = sb4.pop_front(); e20 = sb20.pop_front(); eq = sbq.pop_front();
    n_checks += 3;
    if (cnt4 !== e4) begin
      n_fail++; $display("FAIL reset_cnt4: got %h want %h", cnt4, e4);
    end
    if (cnt20 !== e20) begin
      n_fail++; $display("FAIL reset_cnt20: got %h want %h", cnt20, e20);
    end
    if (q !== eq) begin
      n_fail++; $display("FAIL reset_q: got %h want %h", q, eq);
    end
    tick();
    rst_b = 1;
    m4 = 0; m20 = 0; mq = 0;
    inc_cnt4 = 1; up4 = 1; ld_reg = 1; d = 64'hAABBCCDD;
    for (int i = 0; i < 5; i++) begin
      m4 = m4 + 4'd1; mq = d;
      tick();
      ld_reg = 0;
    end
    idle();
    sb4.push_back(m4); sbq.push_back(mq);
    e4 = sb4.pop_front(); eq = sbq.pop_front();
    n_checks += 2;
    if (cnt4 !== e4) begin
      n_fail++; $display("FAIL preset_cnt4: got %h want %h", cnt4, e4);
    end
    if (q !== eq) begin
      n_fail++; $display("FAIL preset_q: got %h want %h", q, eq);
    end
    // Assert reset mid-cycle and look before the next edge
    #2;
    rst_b = 0;
    m4 = 0; m20 = 0; mq = 0;
    #1;
    sb4.push_back(m4); sbq.push_back(mq);
    e4 = sb4.pop_front(); eq = sbq.pop_front();
    n_checks += 2;
    if (cnt4 !== e4) begin
      n_fail++; $display("FAIL async_rst_cnt4: got %h want %h", cnt4, e4);
    end
    if (q !== eq) begin
      n_fail++; $display("FAIL async_rst_q: got %h want %h", q, eq);
    end
    inc_cnt4 = 1; up4 = 1; ld_reg = 1; d = 64'h55;
    inc_cnt20 = 1; up20 = 1;
    for (int i = 0; i < 2; i++) begin
      sb4.push_back(m4); sb20.push_back(m20); sbq.push_back(mq);
      tick();
      e4 = sb4.pop_front(); e20 = sb20.pop_front(); eq = sbq.pop_front();
      n_checks += 3;
      if (cnt4 !== e4) begin
        n_fail++; $display("FAIL rst_hold_cnt4: got %h want %h", cnt4, e4);
      end
      if (cnt20 !== e20) begin
        n_fail++; $display("FAIL rst_hold_cnt20: got %h want %h", cnt20, e20);
      end
      if (q !== eq) begin
        n_fail++; $display("FAIL rst_hold_q: got %h want %h", q, eq);
      end
    end
    idle();
    rst_b = 1;
  endtask

  task automatic test_count_up();
    logic [19:0] e20;
    clr_cnt20 = 1;
    m20 = 0;
    tick();
    clr_cnt20 = 0; inc_cnt20 = 1; up20 = 1;
    for (int i = 0; i < 20; i++) begin
      m20 = m20 + 20'd1;
      sb20.push_back(m20);
      tick();
      e20 = sb20.pop_front();
      n_checks++;
      if (cnt20 !== e20) begin
        n_fail++; $display("FAIL count_up: got %h want %h", cnt20, e20);
      end
    end
    inc_cnt20 = 0;
    for (int i = 0; i < 3; i++) begin
      sb20.push_back(m20);
      tick();
      e20 = sb20.pop_front();
      n_checks++;
      if (cnt20 !== e20) begin
        n_fail++; $display("FAIL count_hold: got %h want %h", cnt20, e20);
      end
    end
    if (m20 != 20'd20) begin
      n_fail++; $display("FAIL count_model: got %h want 14", m20);
    end
    idle();
  endtask

  task automatic test_wrap();
    logic [3:0] e4;
    logic [3:0] steps_up[4];
    steps_up = '{1'b0, 1'b1, 1'b0, 1'b0};
    clr_cnt4 = 1;
    m4 = 0;
    tick();
    clr_cnt4 = 0; inc_cnt4 = 1;
    // 0 -> 15 -> 0 -> 15 -> 14 -> 13
    for (int i = 0; i < 5; i++) begin
      up4 = (i < 4) ? steps_up[i][0] : 1'b0;
      if (up4) m4 = (m4 == 4'hF) ? 4'h0 : m4 + 4'd1;
      else     m4 = (m4 == 4'h0) ? 4'hF : m4 - 4'd1;
      sb4.push_back(m4);
      tick();
      e4 = sb4.pop_front();
      n_checks++;
      if (cnt4 !== e4) begin
        n_fail++; $display("FAIL wrap_step%0d: got %h want %h", i, cnt4, e4);
      end
    end
    if (cnt4 !== 4'd13) begin
      n_fail++; $display("FAIL wrap_final: got %h want d", cnt4);
    end
    n_checks++;
    idle();
  endtask

  task automatic test_clear_priority();
    logic [3:0]  e4;
    logic [63:0] eq;
    clr_cnt4 = 1;
    tick();
    clr_cnt4 = 0; inc_cnt4 = 1; up4 = 1;
    repeat (7) tick();
    m4 = 4'd7;
    idle();
    clr_cnt4 = 1; inc_cnt4 = 1; up4 = 1;
    sb4.push_back(4'd7);
    e4 = sb4.pop_front();
    n_checks++;
    if (cnt4 !== e4) begin
      n_fail++; $display("FAIL clr_pre_cnt4: got %h want %h", cnt4, e4);
    end
    m4 = 0;
    sb4.push_back(m4);
    tick();
    e4 = sb4.pop_front();
    n_checks++;
    if (cnt4 !== e4) begin
      n_fail++; $display("FAIL clr_prio_cnt4: got %h want %h", cnt4, e4);
    end
    idle();
    ld_reg = 1; d = 64'hFFFF0000FFFF0000;
    tick();
    clr_reg = 1; ld_reg = 1; d = 64'h1234;
    mq = 0;
    sbq.push_back(mq);
    tick();
    eq = sbq.pop_front();
    n_checks++;
    if (q !== eq) begin
      n_fail++; $display("FAIL clr_prio_q: got %h want %h", q, eq);
    end
    idle();
  endtask

  task automatic test_load_hold();
    logic [63:0] eq;
    ld_reg = 1; d = 64'hAABBCCDD;
    mq = 64'hAABBCCDD;
    sbq.push_back(mq);
    tick();
    eq = sbq.pop_front();
    n_checks++;
    if (q !== eq) begin
      n_fail++; $display("FAIL load: got %h want %h", q, eq);
    end
    ld_reg = 0; d = 64'h0;
    for (int i = 0; i < 10; i++) begin
      sbq.push_back(mq);
      tick();
      eq = sbq.pop_front();
      n_checks++;
      if (q !== eq) begin
        n_fail++; $display("FAIL hold%0d: got %h want %h", i, q, eq);
      end
    end
  endtask

  task automatic test_no_feedthrough();
    logic [3:0]  e4;
    logic [63:0] eq;
    #2;
    ld_reg = 1; d = 64'h0123456789ABCDEF;
    inc_cnt4 = 1; up4 = 1;
    #2;
    sb4.push_back(m4); sbq.push_back(mq);
    e4 = sb4.pop_front(); eq = sbq.pop_front();
    n_checks += 2;
    if (q !== eq) begin
      n_fail++; $display("FAIL feedthru_q: got %h want %h", q, eq);
    end
    if (cnt4 !== e4) begin
      n_fail++; $display("FAIL feedthru_cnt4: got %h want %h", cnt4, e4);
    end
    mq = d;
    m4 = m4 + 4'd1;
    sb4.push_back(m4); sbq.push_back(mq);
    tick();
    e4 = sb4.pop_front(); eq = sbq.pop_front();
    n_checks += 2;
    if (q !== eq) begin
      n_fail++; $display("FAIL next_edge_q: got %h want %h", q, eq);
    end
    if (cnt4 !== e4) begin
      n_fail++; $display("FAIL next_edge_cnt4: got %h want %h", cnt4, e4);
    end
    idle();
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_count_up();
        test_wrap();
        test_clear_priority();
        test_load_hold();
        test_no_feedthrough();
      end
      begin
        #20000;
        n_fail++;
        $display("FAIL timeout: got expired want done");
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
